// File: rtl/cmp_share_ctrl_if.sv
// Bundle between the two operand sources, the shared compare unit
// and cmp_share_ctrl. master = controller side, slave = sources/unit side.
interface cmp_share_ctrl_if #(
  parameter int W  = 4,
  parameter int RW = 5
);
  logic          req0;
  logic [W-1:0]  a0;
  logic [W-1:0]  b0;
  logic          req1;
  logic [W-1:0]  a1;
  logic [W-1:0]  b1;
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic [RW-1:0] res;
  logic          res_id;
  logic          busy;
  logic          cmp_en;
  logic [W-1:0]  cmp_a;
  logic [W-1:0]  cmp_b;
  logic [RW-1:0] cmp_result;

  modport master (
    input  req0, a0, b0,
    input  req1, a1, b1,
    input  cmp_result,
    output gnt0, gnt1,
    output done0, done1,
    output res, res_id, busy,
    output cmp_en, cmp_a, cmp_b
  );

  modport slave (
    output req0, a0, b0,
    output req1, a1, b1,
    output cmp_result,
    input  gnt0, gnt1,
    input  done0, done1,
    input  res, res_id, busy,
    input  cmp_en, cmp_a, cmp_b
  );
endinterface

// File: rtl/cmp_share_ctrl.sv
// Round-robin sharing of one compare datapath between two requesters.
// Ports: clk, rst (async, active-high), bus (cmp_share_ctrl_if.master):
//   req/a/b per requester in, gnt/done pulses out, res/res_id/busy out,
//   cmp_en/cmp_a/cmp_b to the compare unit, cmp_result back from it.
module cmp_share_ctrl #(
  parameter int W   = 4,
  parameter int RW  = 5,
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  cmp_share_ctrl_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAT4 = 4'(LAT);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic [RW-1:0] res_q, res_d;
  logic          res_id_q, res_id_d;
  logic          busy_q, busy_d;
  logic          en_q, en_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;

  logic          any_req;
  logic          win;

  assign any_req = bus.req0 | bus.req1;

  // On a tie the requester that was not served last wins.
  assign win = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    res_d    = res_q;
    res_id_d = res_id_q;
    en_d     = en_q;
    a_d      = a_q;
    b_d      = b_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          a_d     = win ? bus.a1 : bus.a0;
          b_d     = win ? bus.b1 : bus.b0;
          en_d    = 1'b1;
          gnt0_d  = ~win;
          gnt1_d  = win;
          cnt_d   = LAT4;
          last_d  = win;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          // last_q still names the requester granted for this op
          res_d    = bus.cmp_result;
          res_id_d = last_q;
          done0_d  = ~last_q;
          done1_d  = last_q;
          en_d     = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      res_q    <= '0;
      res_id_q <= 1'b0;
      busy_q   <= 1'b0;
      en_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      res_q    <= res_d;
      res_id_q <= res_id_d;
      busy_q   <= busy_d;
      en_q     <= en_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.res    = res_q;
  assign bus.res_id = res_id_q;
  assign bus.busy   = busy_q;
  assign bus.cmp_en = en_q;
  assign bus.cmp_a  = a_q;
  assign bus.cmp_b  = b_q;

endmodule

// File: tb/tb_cmp_share_ctrl.sv
// Bench: three controllers (LAT=1,2,3), directed scenarios then random
// traffic, each cycle compared against a transaction-level timing model.
module tb_cmp_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v   [3];
  logic       req0_v  [3];
  logic       req1_v  [3];
  logic [3:0] a0_v    [3];
  logic [3:0] b0_v    [3];
  logic [3:0] a1_v    [3];
  logic [3:0] b1_v    [3];
  logic       gnt0_v  [3];
  logic       gnt1_v  [3];
  logic       done0_v [3];
  logic       done1_v [3];
  logic       rid_v   [3];
  logic       busy_v  [3];
  logic       en_v    [3];
  logic [4:0] res_v   [3];
  logic [3:0] ca_v    [3];
  logic [3:0] cb_v    [3];

  for (genvar g = 0; g < 3; g++) begin : gi
    cmp_share_ctrl_if #(.W(4), .RW(5)) bus ();
    cmp_share_ctrl #(.W(4), .RW(5), .LAT(g + 1)) dut (
      .clk (clk),
      .rst (rst_v[g]),
      .bus (bus.master)
    );
    assign bus.req0 = req0_v[g];
    assign bus.a0   = a0_v[g];
    assign bus.b0   = b0_v[g];
    assign bus.req1 = req1_v[g];
    assign bus.a1   = a1_v[g];
    assign bus.b1   = b1_v[g];
    assign bus.cmp_result = bus.cmp_en ?
      {1'b1, bus.cmp_a ^ bus.cmp_b} : 5'd0;
    assign gnt0_v[g]  = bus.gnt0;
    assign gnt1_v[g]  = bus.gnt1;
    assign done0_v[g] = bus.done0;
    assign done1_v[g] = bus.done1;
    assign rid_v[g]   = bus.res_id;
    assign busy_v[g]  = bus.busy;
    assign en_v[g]    = bus.cmp_en;
    assign res_v[g]   = bus.res;
    assign ca_v[g]    = bus.cmp_a;
    assign cb_v[g]    = bus.cmp_b;
  end

  int nvec = 0;
  int nerr = 0;

  // Transaction-level model: a grant at edge g implies fixed windows
  // (gnt at g, en over g..g+L-1, done at g+L, free again at g+L+2).
  int         m_n    [3];
  int         m_free [3];
  int         m_g    [3];
  logic       m_last [3];
  logic       m_w    [3];
  logic [3:0] m_a    [3];
  logic [3:0] m_b    [3];
  logic [4:0] m_res  [3];
  logic       m_id   [3];

  task automatic chk(input string tag, input int i,
                     input logic [31:0] o, input logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s[%0d] observed %0h expected %0h", tag, i, o, e);
    end
  endtask

  task automatic m_init(input int i);
    m_n[i]    = 0;
    m_free[i] = 0;
    m_g[i]    = -100;
    m_last[i] = 1'b1;
    m_w[i]    = 1'b0;
    m_a[i]    = '0;
    m_b[i]    = '0;
    m_res[i]  = '0;
    m_id[i]   = 1'b0;
  endtask

  task automatic chk_zero(input int i);
    chk("rst_gnt0", i, gnt0_v[i], 0);
    chk("rst_gnt1", i, gnt1_v[i], 0);
    chk("rst_done0", i, done0_v[i], 0);
    chk("rst_done1", i, done1_v[i], 0);
    chk("rst_busy", i, busy_v[i], 0);
    chk("rst_en", i, en_v[i], 0);
    chk("rst_res", i, res_v[i], 0);
    chk("rst_rid", i, rid_v[i], 0);
    chk("rst_a", i, ca_v[i], 0);
    chk("rst_b", i, cb_v[i], 0);
  endtask

  task automatic do_reset(input int i);
    req0_v[i] = 1'b0;
    req1_v[i] = 1'b0;
    rst_v[i]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_v[i] = 1'b0;
    m_init(i);
  endtask

  task automatic tick(input int i);
    int   L, d;
    logic w;
    bit   eg, ee, ed, eb;
    L = i + 1;
    if (m_n[i] >= m_free[i] && (req0_v[i] || req1_v[i])) begin
      if (req0_v[i] && req1_v[i]) w = ~m_last[i];
      else w = req1_v[i];
      m_g[i]    = m_n[i];
      m_w[i]    = w;
      m_last[i] = w;
      m_a[i]    = w ? a1_v[i] : a0_v[i];
      m_b[i]    = w ? b1_v[i] : b0_v[i];
      m_free[i] = m_n[i] + L + 2;
    end
    d  = m_n[i] - m_g[i];
    eg = (d == 0);
    ee = (d >= 0 && d < L);
    ed = (d == L);
    eb = (d >= 0 && d <= L);
    if (ed) begin
      m_res[i] = {1'b1, m_a[i] ^ m_b[i]};
      m_id[i]  = m_w[i];
    end
    m_n[i]++;
    @(posedge clk);
    @(negedge clk);
    chk("gnt0", i, gnt0_v[i], eg && !m_w[i]);
    chk("gnt1", i, gnt1_v[i], eg && m_w[i]);
    chk("done0", i, done0_v[i], ed && !m_w[i]);
    chk("done1", i, done1_v[i], ed && m_w[i]);
    chk("busy", i, busy_v[i], eb);
    chk("cmp_en", i, en_v[i], ee);
    chk("cmp_a", i, ca_v[i], m_a[i]);
    chk("cmp_b", i, cb_v[i], m_b[i]);
    chk("res", i, res_v[i], m_res[i]);
    chk("res_id", i, rid_v[i], m_id[i]);
  endtask

  task automatic drive_rand(input int i);
    if (req0_v[i]) begin
      if (gnt0_v[i]) begin
        if ($urandom_range(1) == 1) begin
          a0_v[i] = 4'($urandom_range(15));
          b0_v[i] = 4'($urandom_range(15));
        end else begin
          req0_v[i] = 1'b0;
        end
      end
    end else if ($urandom_range(9) < 4) begin
      req0_v[i] = 1'b1;
      a0_v[i]   = 4'($urandom_range(15));
      b0_v[i]   = 4'($urandom_range(15));
    end
    if (req1_v[i]) begin
      if (gnt1_v[i]) begin
        if ($urandom_range(1) == 1) begin
          a1_v[i] = 4'($urandom_range(15));
          b1_v[i] = 4'($urandom_range(15));
        end else begin
          req1_v[i] = 1'b0;
        end
      end
    end else if ($urandom_range(9) < 4) begin
      req1_v[i] = 1'b1;
      a1_v[i]   = 4'($urandom_range(15));
      b1_v[i]   = 4'($urandom_range(15));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_v[i]  = 1'b1;
      req0_v[i] = 1'b0;
      req1_v[i] = 1'b0;
      a0_v[i]   = '0;
      b0_v[i]   = '0;
      a1_v[i]   = '0;
      b1_v[i]   = '0;
      m_init(i);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk_zero(i);
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;

    // LAT=1 single request
    req0_v[0] = 1'b1; a0_v[0] = 4'd8; b0_v[0] = 4'd0;
    tick(0);
    chk("t1_gnt0", 0, gnt0_v[0], 1);
    chk("t1_en", 0, en_v[0], 1);
    chk("t1_a", 0, ca_v[0], 8);
    req0_v[0] = 1'b0;
    tick(0);
    chk("t1_done0", 0, done0_v[0], 1);
    chk("t1_res", 0, res_v[0], 5'h18);
    tick(0);
    chk("t1_busy", 0, busy_v[0], 0);

    // LAT=1 both requesting: alternating grants every 3 cycles
    do_reset(0);
    req0_v[0] = 1'b1; a0_v[0] = 4'd0; b0_v[0] = 4'd8;
    req1_v[0] = 1'b1; a1_v[0] = 4'd3; b1_v[0] = 4'd1;
    for (int t = 1; t <= 12; t++) begin
      tick(0);
      if (t == 1 || t == 7) chk("t2_gnt0", 0, gnt0_v[0], 1);
      if (t == 4 || t == 10) chk("t2_gnt1", 0, gnt1_v[0], 1);
      if (t == 2) chk("t2_res0", 0, res_v[0], 5'h18);
      if (t == 5) chk("t2_res1", 0, res_v[0], 5'h12);
      if (t == 5) chk("t2_rid1", 0, rid_v[0], 1);
    end
    req0_v[0] = 1'b0; req1_v[0] = 1'b0;

    // LAT=3 single request, operand change during RUN ignored
    do_reset(2);
    req1_v[2] = 1'b1; a1_v[2] = 4'd15; b1_v[2] = 4'd15;
    tick(2);
    chk("t3_gnt1", 2, gnt1_v[2], 1);
    req1_v[2] = 1'b0; a1_v[2] = 4'd0;
    tick(2);
    tick(2);
    chk("t3_en", 2, en_v[2], 1);
    chk("t3_a", 2, ca_v[2], 15);
    tick(2);
    chk("t3_done1", 2, done1_v[2], 1);
    chk("t3_en_off", 2, en_v[2], 0);
    chk("t3_res", 2, res_v[2], 5'h10);

    // Reset in the 2nd RUN cycle of a req0 op, req1 pending
    do_reset(2);
    req0_v[2] = 1'b1; a0_v[2] = 4'd9; b0_v[2] = 4'd2;
    tick(2);
    req0_v[2] = 1'b0;
    req1_v[2] = 1'b1; a1_v[2] = 4'd5; b1_v[2] = 4'd6;
    tick(2);
    rst_v[2] = 1'b1;
    #1;
    chk_zero(2);
    @(posedge clk);
    @(negedge clk);
    rst_v[2] = 1'b0;
    m_init(2);
    tick(2);
    chk("t4_gnt1", 2, gnt1_v[2], 1);
    req1_v[2] = 1'b0;
    repeat (4) tick(2);

    // LAT=2 back-to-back from one requester
    do_reset(1);
    req0_v[1] = 1'b1; a0_v[1] = 4'd0; b0_v[1] = 4'd5;
    for (int t = 1; t <= 16; t++) begin
      tick(1);
      if ((t % 4) == 1) chk("t5_gnt0", 1, gnt0_v[1], 1);
      if ((t % 4) == 3) chk("t5_res", 1, res_v[1],
                            {1'b1, 4'((t - 3) / 4) ^ 4'd5});
      if (gnt0_v[1]) begin
        if (a0_v[1] == 4'd3) req0_v[1] = 1'b0;
        else a0_v[1] = a0_v[1] + 4'd1;
      end
    end

    // Random traffic on every latency
    for (int i = 0; i < 3; i++) begin
      do_reset(i);
      repeat (250) begin
        tick(i);
        drive_rand(i);
      end
      req0_v[i] = 1'b0;
      req1_v[i] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
